// File: rtl/button_press_ctrl.sv
// rtl/button_press_ctrl.sv - debounced press/repeat/release sequencer for one front-panel button
module button_press_ctrl #(
    parameter int unsigned SUFFICIENT_CYCLES = 5,
    parameter int unsigned HOLD_CYCLES       = 50,
    parameter int unsigned REPEAT_CYCLES     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_synchr,
    input  logic       repeat_en,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       repeat_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ARM_PRESS   = 3'd1,
        PRESSED     = 3'd2,
        REPEAT      = 3'd3,
        ARM_RELEASE = 3'd4
    } state_t;

    localparam logic [15:0] SUFF_LAST = 16'(SUFFICIENT_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] REP_LAST  = 16'(REPEAT_CYCLES - 1);

    state_t      st;
    logic [15:0] cnt;

    assign state = st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st            <= IDLE;
            cnt           <= 16'd0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            case (st)
                IDLE: begin
                    if (btn_synchr) begin
                        st  <= ARM_PRESS;
                        cnt <= 16'd1;
                    end
                end
                ARM_PRESS: begin
                    if (!btn_synchr) begin
                        st  <= IDLE;
                        cnt <= 16'd0;
                    end else if (cnt == SUFF_LAST) begin
                        st          <= PRESSED;
                        cnt         <= 16'd0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PRESSED: begin
                    // A low sample always wins over hold expiry on the same edge.
                    if (!btn_synchr) begin
                        st  <= ARM_RELEASE;
                        cnt <= 16'd1;
                    end else if (repeat_en && cnt == HOLD_LAST) begin
                        st           <= REPEAT;
                        cnt          <= 16'd0;
                        repeat_pulse <= 1'b1;
                        press_count  <= press_count + 8'd1;
                    end else if (cnt != HOLD_LAST) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                REPEAT: begin
                    if (!btn_synchr) begin
                        st  <= ARM_RELEASE;
                        cnt <= 16'd1;
                    end else if (!repeat_en) begin
                        st  <= PRESSED;
                        cnt <= 16'd0;
                    end else if (cnt == REP_LAST) begin
                        cnt          <= 16'd0;
                        repeat_pulse <= 1'b1;
                        press_count  <= press_count + 8'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ARM_RELEASE: begin
                    // Bounce back high keeps the button held but restarts the hold timer.
                    if (btn_synchr) begin
                        st  <= PRESSED;
                        cnt <= 16'd0;
                    end else if (cnt == SUFF_LAST) begin
                        st            <= IDLE;
                        cnt           <= 16'd0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    st          <= IDLE;
                    cnt         <= 16'd0;
                    btn_level   <= 1'b0;
                    press_count <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_ctrl.sv
// tb/tb_button_press_ctrl.sv - self-checking bench for button_press_ctrl
module tb_button_press_ctrl;

    localparam int SUFF = 5;
    localparam int HOLD = 20;
    localparam int REP  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_synchr = 1'b0;
    logic       repeat_en = 1'b0;
    logic       btn_level;
    logic       press_pulse;
    logic       repeat_pulse;
    logic       release_pulse;
    logic [7:0] press_count;
    logic [2:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    button_press_ctrl #(
        .SUFFICIENT_CYCLES(SUFF),
        .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_synchr(btn_synchr),
        .repeat_en(repeat_en),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .repeat_pulse(repeat_pulse),
        .release_pulse(release_pulse),
        .press_count(press_count),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: debounced level, run lengths of qualifying samples, time since last hold-timer restart.
    bit m_level = 0, m_repeating = 0;
    bit m_press = 0, m_rep = 0, m_rel = 0;
    int m_run_hi = 0, m_run_lo = 0, m_timer = 0, m_count = 0;

    function automatic int m_state();
        if (!m_level) return (m_run_hi > 0) ? 1 : 0;
        if (m_run_lo > 0) return 4;
        return m_repeating ? 3 : 2;
    endfunction

    always @(posedge clk or negedge reset) begin
        m_press = 0; m_rep = 0; m_rel = 0;
        if (!reset) begin
            m_level = 0; m_repeating = 0;
            m_run_hi = 0; m_run_lo = 0; m_timer = 0; m_count = 0;
        end else if (!m_level) begin
            if (btn_synchr) begin
                m_run_hi++;
                if (m_run_hi == SUFF) begin
                    m_level = 1; m_press = 1; m_run_hi = 0;
                    m_timer = 0; m_repeating = 0;
                    m_count = (m_count + 1) % 256;
                end
            end else m_run_hi = 0;
        end else if (!btn_synchr) begin
            m_run_lo++;
            if (m_run_lo == SUFF) begin
                m_level = 0; m_rel = 1; m_run_lo = 0; m_repeating = 0;
            end
        end else if (m_run_lo > 0) begin
            m_run_lo = 0; m_timer = 0; m_repeating = 0;
        end else begin
            m_timer++;
            if (repeat_en) begin
                if (m_timer >= (m_repeating ? REP : HOLD)) begin
                    m_rep = 1; m_timer = 0; m_repeating = 1;
                    m_count = (m_count + 1) % 256;
                end
            end else if (m_repeating) begin
                m_repeating = 0; m_timer = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model btn_level", int'(btn_level), int'(m_level));
        chk("model press_pulse", int'(press_pulse), int'(m_press));
        chk("model repeat_pulse", int'(repeat_pulse), int'(m_rep));
        chk("model release_pulse", int'(release_pulse), int'(m_rel));
        chk("model press_count", int'(press_count), m_count);
        chk("model state", int'(state), m_state());
    end

    task automatic tick(input logic b);
        btn_synchr = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1'b0);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", int'(state), 0);
        chk("reset press_count", int'(press_count), 0);
        chk("reset btn_level", int'(btn_level), 0);
        reset = 1'b1;

        // Glitch rejection
        repeat (3) tick(1'b1);
        chk("glitch arm state", int'(state), 1);
        repeat (10) begin
            tick(1'b0);
            chk("glitch no press", int'(press_pulse), 0);
        end
        chk("glitch state", int'(state), 0);
        chk("glitch count", int'(press_count), 0);
        chk("glitch level", int'(btn_level), 0);

        // Clean press and release
        repeat (4) begin
            tick(1'b1);
            chk("press early", int'(press_pulse), 0);
        end
        tick(1'b1);
        chk("press pulse", int'(press_pulse), 1);
        chk("press level", int'(btn_level), 1);
        chk("press count", int'(press_count), 1);
        chk("press state", int'(state), 2);
        repeat (7) tick(1'b1);
        repeat (4) begin
            tick(1'b0);
            chk("release early", int'(release_pulse), 0);
            chk("release level held", int'(btn_level), 1);
        end
        tick(1'b0);
        chk("release pulse", int'(release_pulse), 1);
        chk("release level", int'(btn_level), 0);
        chk("release count", int'(press_count), 1);

        // Auto-repeat
        do_reset();
        repeat_en = 1'b1;
        repeat (5) tick(1'b1);
        chk("rpt press", int'(press_pulse), 1);
        for (int k = 1; k <= 38; k++) begin
            tick(1'b1);
            chk("rpt timing", int'(repeat_pulse), (k >= 20 && (k - 20) % 4 == 0) ? 1 : 0);
        end
        repeat (5) tick(1'b0);
        chk("rpt release", int'(release_pulse), 1);
        chk("rpt count", int'(press_count), 6);

        // Release bounce
        repeat (5) tick(1'b1);
        repeat (3) tick(1'b1);
        repeat (2) tick(1'b0);
        chk("bounce arm state", int'(state), 4);
        tick(1'b1);
        chk("bounce state", int'(state), 2);
        chk("bounce level", int'(btn_level), 1);
        chk("bounce no release", int'(release_pulse), 0);
        for (int k = 1; k <= 20; k++) begin
            tick(1'b1);
            chk("bounce hold restart", int'(repeat_pulse), (k == 20) ? 1 : 0);
        end
        repeat (5) tick(1'b0);

        // Repeat disabled, then enabled after saturation
        repeat_en = 1'b0;
        repeat (5) tick(1'b1);
        for (int k = 1; k <= 60; k++) begin
            tick(1'b1);
            chk("disabled no repeat", int'(repeat_pulse), 0);
        end
        chk("disabled state", int'(state), 2);
        repeat_en = 1'b1;
        tick(1'b1);
        chk("enable repeat", int'(repeat_pulse), 1);
        chk("enable state", int'(state), 3);

        // Asynchronous reset mid-REPEAT
        repeat (2) tick(1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async level", int'(btn_level), 0);
        chk("async count", int'(press_count), 0);
        chk("async state", int'(state), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) begin
            tick(1'b1);
            chk("post reset early", int'(press_pulse), 0);
        end
        chk("post reset arm", int'(state), 1);
        tick(1'b1);
        chk("post reset press", int'(press_pulse), 1);
        chk("post reset count", int'(press_count), 1);
        tick(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/button_press_ctrl.md
Name: button_press_ctrl

Overview:
Press/release sequencer for one front-panel button. It takes an already-synchronized button level and qualifies press and release with a shared stability counter. It then emits single-cycle press, auto-repeat and release events, plus a wrapping event count for the 7-segment display path. It sits between the reset/button synchronizer and the display/LED logic.

Parameters:
SUFFICIENT_CYCLES, 5, consecutive equal samples needed to accept a press or a release; legal range 2..65535.
HOLD_CYCLES, 50, cycles from press_pulse to the first repeat_pulse; legal range 2..65535.
REPEAT_CYCLES, 10, cycles between successive repeat_pulse; legal range 2..65535.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
btn_synchr  input  1  synchronized button level, 1 = pressed.
repeat_en  input  1  enables auto-repeat.
btn_level  output  1  debounced button level.
press_pulse  output  1  one-cycle pulse on an accepted press.
repeat_pulse  output  1  one-cycle pulse per auto-repeat.
release_pulse  output  1  one-cycle pulse on an accepted release.
press_count  output  8  count of press_pulse plus repeat_pulse events; wraps 255 -> 0.
state  output  3  current FSM state (debug).

Behaviour:
- All outputs and state are registered. There is a single 16-bit counter cnt.
- Reset low, applied at any time: state=IDLE, cnt=0, all outputs 0, immediately and without waiting for clk. Operation resumes on the first rising edge after reset goes high.
- State encoding: IDLE=0, ARM_PRESS=1, PRESSED=2, REPEAT=3, ARM_RELEASE=4. Codes 5-7 go to IDLE on the next edge with outputs cleared.
- Pulse outputs default to 0 every cycle and are high only for the cycle after the edge that generates them.
- IDLE:
  - btn_synchr=1 -> ARM_PRESS, cnt=1.
  - Otherwise remain in IDLE.
- ARM_PRESS:
  - btn_synchr=0 -> IDLE, cnt=0. The glitch is rejected with no outputs.
  - btn_synchr=1 and cnt==SUFFICIENT_CYCLES-1 -> PRESSED, cnt=0, btn_level=1, press_pulse=1, press_count+1.
  - btn_synchr=1 otherwise -> cnt+1.
  - Net effect: press_pulse is high in the cycle after the SUFFICIENT_CYCLES-th consecutive high sample.
- PRESSED:
  - btn_synchr=0 -> ARM_RELEASE, cnt=1.
  - Else if repeat_en=1 and cnt==HOLD_CYCLES-1 -> REPEAT, cnt=0, repeat_pulse=1, press_count+1.
  - Else cnt+1, saturating at HOLD_CYCLES-1 while repeat_en=0.
  - First repeat_pulse occurs exactly HOLD_CYCLES cycles after press_pulse.
- REPEAT:
  - btn_synchr=0 -> ARM_RELEASE, cnt=1.
  - Else if repeat_en=0 -> PRESSED, cnt=0, no pulse.
  - Else if cnt==REPEAT_CYCLES-1 -> cnt=0, repeat_pulse=1, press_count+1.
  - Else cnt+1.
- ARM_RELEASE:
  - btn_synchr=1 -> PRESSED, cnt=0. Bounce is rejected, btn_level stays 1, the hold timer restarts and repeat stops.
  - btn_synchr=0 and cnt==SUFFICIENT_CYCLES-1 -> IDLE, cnt=0, btn_level=0, release_pulse=1.
  - btn_synchr=0 otherwise -> cnt+1.
- Priority: a release sample beats hold/repeat expiry on the same edge (go to ARM_RELEASE, no repeat_pulse).
- press_pulse, repeat_pulse and release_pulse are mutually exclusive. press_count increments by at most 1 per cycle.
- btn_level changes only on the edges that assert press_pulse or release_pulse.

Test Plan:
(Bench overrides: SUFFICIENT_CYCLES=5, HOLD_CYCLES=20, REPEAT_CYCLES=4.)
1. Glitch rejection: reset, then btn_synchr high for 3 cycles, then low for 10 -> no pulses, btn_level=0, press_count=0, state returns to 0.
2. Clean press and release: btn_synchr high for 12 cycles -> press_pulse high in the cycle after the 5th high edge, btn_level=1, press_count=1. Then low -> release_pulse in the cycle after the 5th low edge, btn_level=0.
3. Auto-repeat, repeat_en=1: hold until 38 cycles after press_pulse -> repeat_pulse at +20, +24, +28, +32, +36; after the 5-cycle release, press_count=6.
4. Release bounce: in PRESSED, drive low for 2 cycles, then high -> no release_pulse, btn_level stays 1, state=2. First repeat_pulse comes 20 cycles after returning to PRESSED.
5. Repeat disabled: repeat_en=0, hold for 60 cycles after press -> no repeat_pulse, state stays 2. Raising repeat_en then gives repeat_pulse on the next edge.
6. Async reset mid-REPEAT: pull reset low between edges -> btn_level, press_count and state are 0 before the next clk edge. After reset releases with btn_synchr high, a full 5-sample press is needed again.
